// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared types and constants for the ccff chain loader
package ccff_loader_pkg;

    localparam int WORD_W = 8;
    localparam logic [WORD_W-1:0] TAIL_MARKER = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MARK = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ccff_loader_ser.sv
// rtl/ccff_loader_ser.sv - 8-bit load/shift buffer feeding the chain head, LSB first
module ccff_loader_ser
    import ccff_loader_pkg::*;
(
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [3:0]        load_len,
    output logic              empty,
    output logic              bit_vld,
    output logic              bit_out
);

    logic [WORD_W-1:0] sh_q, sh_d;
    logic [3:0]        left_q, left_d;
    logic              pres_q, pres_d;

    // Bit 0 goes out on the load cycle itself; the rest drain one per cycle.
    always_comb begin
        sh_d    = sh_q;
        left_d  = left_q;
        pres_d  = 1'b0;
        bit_vld = 1'b0;
        bit_out = sh_q[0];
        if (load) begin
            bit_vld = 1'b1;
            bit_out = load_data[0];
            sh_d    = load_data >> 1;
            left_d  = load_len - 4'd1;
            pres_d  = 1'b1;
        end else if (left_q != 4'd0) begin
            bit_vld = 1'b1;
            bit_out = sh_q[0];
            sh_d    = sh_q >> 1;
            left_d  = left_q - 4'd1;
            pres_d  = 1'b1;
        end
    end

    // Empty only once the last bit has left the head, giving the inter-word bubble.
    assign empty = (left_q == 4'd0) && !pres_q;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            sh_q   <= '0;
            left_q <= '0;
            pres_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            left_q <= left_d;
            pres_q <= pres_d;
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - serial ccff chain loader; CCFF_LOADER_TAILCHK_EN adds the A5 tail marker check
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 19
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              cfg_valid,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
`ifdef CCFF_LOADER_TAILCHK_EN
    ,
    output logic              tail_ok
`endif
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 9);
`ifdef CCFF_LOADER_TAILCHK_EN
    localparam int MARK_BITS = WORD_W;
    localparam logic [2:0] LEN_LO = 3'(CHAIN_LEN % 8);
`else
    localparam int MARK_BITS = 0;
`endif
    localparam int TOTAL = CHAIN_LEN + MARK_BITS;

    state_t           state_q, state_d;
    logic             head_q, head_d;
    logic             en_q, en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] iss_q, iss_d;
    logic [CNT_W-1:0] rem;
    logic [3:0]       load_len;
    logic [2:0]       mark_idx;
    logic             ser_load;
    logic             ser_empty;
    logic             ser_bit_vld;
    logic             ser_bit;

    // Host handshake: iss_q counts config bits already handed to the buffer.
    always_comb begin
        rem       = CNT_W'(CHAIN_LEN) - iss_q;
        load_len  = (rem >= CNT_W'(WORD_W)) ? 4'(WORD_W) : rem[3:0];
        cfg_ready = (state_q == ST_LOAD) && ser_empty && (iss_q < CNT_W'(CHAIN_LEN));
        ser_load  = cfg_valid && cfg_ready;
    end

    ccff_loader_ser u_ser (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .load      (ser_load),
        .load_data (cfg_data),
        .load_len  (load_len),
        .empty     (ser_empty),
        .bit_vld   (ser_bit_vld),
        .bit_out   (ser_bit)
    );

`ifdef CCFF_LOADER_TAILCHK_EN
    logic       match_q, match_d;
    logic [2:0] tail_idx;
    assign tail_idx = cnt_q[2:0] - LEN_LO;
    assign tail_ok  = (state_q == ST_DONE) && match_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

    // cnt_q counts completed chain shifts, marker bits included.
    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        en_d     = 1'b0;
        cnt_d    = en_q ? cnt_q + 1'b1 : cnt_q;
        iss_d    = ser_load ? iss_q + CNT_W'(load_len) : iss_q;
        mark_idx = cnt_q[2:0] + 3'd1;
`ifdef CCFF_LOADER_TAILCHK_EN
        match_d  = match_q;
        if (en_q && (cnt_q >= CNT_W'(CHAIN_LEN)) && (ccff_tail != TAIL_MARKER[tail_idx])) begin
            match_d = 1'b0;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    iss_d = '0;
`ifdef CCFF_LOADER_TAILCHK_EN
                    match_d = 1'b1;
                    state_d = ST_MARK;
                    head_d  = TAIL_MARKER[0];
                    en_d    = 1'b1;
`else
                    state_d = ST_LOAD;
`endif
                end
            end
            ST_MARK: begin
                if (cnt_q[2:0] == 3'd7) begin
                    state_d = ST_LOAD;
                end else begin
                    head_d = TAIL_MARKER[mark_idx];
                    en_d   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (ser_bit_vld) begin
                    head_d = ser_bit;
                    en_d   = 1'b1;
                end
                if (en_q && (cnt_q == CNT_W'(TOTAL - 1))) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ccff_head = head_q;
    assign ccff_en   = en_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q <= ST_IDLE;
            head_q  <= 1'b0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            iss_q   <= '0;
`ifdef CCFF_LOADER_TAILCHK_EN
            match_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            iss_q   <= iss_d;
`ifdef CCFF_LOADER_TAILCHK_EN
            match_q <= match_d;
`endif
        end
    end

endmodule
